input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 18 +
 rtl/key_debounce.sv | 103 ++++++++++
 rtl/input_conditioner.sv | 52 +++++
 tb/tb_input_conditioner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the board-I/O conditioning blocks.
package input_conditioner_pkg;

    // Default settle time: 20 ms of stable input at a 50 MHz clock.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    localparam int SW_W  = 10;
    localparam int KEY_W = 2;

    // Debounce FSM states, shared by every pushbutton handler.
    typedef enum logic [1:0] {
        KEY_RELEASED     = 2'b00,
        KEY_PRESS_PEND   = 2'b01,
        KEY_PRESSED      = 2'b10,
        KEY_RELEASE_PEND = 2'b11
    } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// Single pushbutton: two-flop synchronizer, debounce FSM with a stability
// counter, and registered level / press / release outputs.
//
// state            | meaning
// -----------------+------------------------------------------------------
// KEY_RELEASED     | key stable released
// KEY_PRESS_PEND   | key reads pressed, waiting for it to stay pressed
// KEY_PRESSED      | key stable pressed
// KEY_RELEASE_PEND | key reads released, waiting for it to stay released
module key_debounce
    import input_conditioner_pkg::*;
#(
    // Must be at least 2 so the counter has a nonzero width.
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_n_i,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta_q;
    logic             key_sync_q;
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             key_pressed;

    // The button is active-low; only the second synchronizer stage is used.
    assign key_pressed = ~key_sync_q;

    // Synchronizer, debounce FSM and registered outputs. The counter only
    // runs up to CNT_LAST, so it can never wrap; any disagreeing sample
    // drops the FSM back to the stable state and the window restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            state_q    <= KEY_RELEASED;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            key_meta_q <= key_raw_n_i;
            key_sync_q <= key_meta_q;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            case (state_q)
                KEY_RELEASED: begin
                    if (key_pressed) begin
                        state_q <= KEY_PRESS_PEND;
                        cnt_q   <= '0;
                    end
                end
                KEY_PRESS_PEND: begin
                    if (!key_pressed) begin
                        state_q <= KEY_RELEASED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= KEY_PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                KEY_PRESSED: begin
                    if (!key_pressed) begin
                        state_q <= KEY_RELEASE_PEND;
                        cnt_q   <= '0;
                    end
                end
                KEY_RELEASE_PEND: begin
                    if (key_pressed) begin
                        state_q <= KEY_PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= KEY_RELEASED;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= KEY_RELEASED;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioning: synchronized switches with change pulses, and
// two independently debounced pushbuttons.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  SW,
    input  logic [KEY_W-1:0] KEY,
    output logic [SW_W-1:0]  sw_sync,
    output logic [SW_W-1:0]  sw_change,
    output logic [KEY_W-1:0] key_level,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release
);

    logic [SW_W-1:0] sw_meta_q;
    logic [SW_W-1:0] sw_sync_q;
    logic [SW_W-1:0] sw_prev_q;

    // Switch synchronizer plus a one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            sw_prev_q <= '0;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            sw_prev_q <= sw_sync_q;
        end
    end

    assign sw_sync   = sw_sync_q;
    assign sw_change = sw_sync_q ^ sw_prev_q;

    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk          (clk),
            .rst          (rst),
            .key_raw_n_i  (KEY[gi]),
            .key_level_o  (key_level[gi]),
            .key_press_o  (key_press[gi]),
            .key_release_o(key_release[gi])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic [9:0] SW;
    logic [1:0] KEY;
    logic [9:0] sw_sync;
    logic [9:0] sw_change;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;

    input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .SW         (SW),
        .KEY        (KEY),
        .sw_sync    (sw_sync),
        .sw_change  (sw_change),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected output snapshot after each rising edge.
    typedef struct packed {
        logic [9:0] sw_sync;
        logic [9:0] sw_change;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: inputs are seen through a 2-sample delay; a key's
    // debounced level flips once DB+1 consecutive delayed samples disagree
    // with the current level, and each flip is one press or release pulse.
    logic [9:0] m_sw1, m_sw2, m_swp;
    logic [1:0] m_k1, m_k2, m_lvl;
    int         m_run [2];

    always @(posedge clk) begin
        exp_t e;
        e = '0;
        if (rst) begin
            m_sw1 = '0; m_sw2 = '0; m_swp = '0;
            m_k1 = 2'b11; m_k2 = 2'b11; m_lvl = 2'b00;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            m_swp = m_sw2; m_sw2 = m_sw1; m_sw1 = SW;
            e.sw_sync   = m_sw2;
            e.sw_change = m_sw2 ^ m_swp;
            for (int k = 0; k < 2; k++) begin
                logic pressed;
                pressed = ~m_k2[k];
                if (pressed != m_lvl[k]) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == DB + 1) begin
                    m_lvl[k] = pressed;
                    if (pressed) e.prs[k] = 1'b1;
                    else e.rel[k] = 1'b1;
                    m_run[k] = 0;
                end
            end
            m_k2 = m_k1; m_k1 = KEY;
        end
        e.lvl = m_lvl;
        exp_q.push_back(e);
    end

    // Monitor: pops one expected snapshot per cycle and compares.
    int press_cnt [2];
    int rel_cnt [2];

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (key_press[k]) press_cnt[k]++;
            if (key_release[k]) rel_cnt[k]++;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_sw_sync",     32'(sw_sync),     32'(e.sw_sync));
            chk("sb_sw_change",   32'(sw_change),   32'(e.sw_change));
            chk("sb_key_level",   32'(key_level),   32'(e.lvl));
            chk("sb_key_press",   32'(key_press),   32'(e.prs));
            chk("sb_key_release", 32'(key_release), 32'(e.rel));
            if ((key_press & key_release) != 2'b00) begin
                checks++;
                failures++;
                $display("FAIL press_and_release_same_cycle: got %b/%b", key_press, key_release);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Edges until key_level[k] reaches want, -1 if it never does.
    task automatic measure_level(input int k, input logic want, output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (key_level[k] === want) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int p0, p1, r0, r1;
        press_cnt[0] = 0; press_cnt[1] = 0;
        rel_cnt[0] = 0; rel_cnt[1] = 0;
        rst = 1'b1;
        SW  = '0;
        KEY = 2'b11;
        idle(3);
        chk("reset_outputs", {sw_sync, sw_change, key_level, key_press, key_release}, 32'h0);
        rst = 1'b0;
        idle(4);

        // Scenario 1: clean press on KEY[0]
        p1 = press_cnt[1];
        KEY[0] = 1'b0;
        measure_level(0, 1'b1, n);
        chk("s1_press_latency", n, 7);
        chk("s1_press_pulse_now", 32'(key_press), 32'h1);
        idle(3);
        chk("s1_key1_level", 32'(key_level[1]), 32'h0);
        chk("s1_key1_presses", press_cnt[1] - p1, 0);
        KEY[0] = 1'b1;
        measure_level(0, 1'b0, n);
        chk("s1_release_latency", n, 7);
        idle(4);

        // Scenario 2: bounce then hold
        p0 = press_cnt[0];
        KEY[0] = 1'b0;
        idle(2);
        KEY[0] = 1'b1;
        idle(2);
        KEY[0] = 1'b0;
        measure_level(0, 1'b1, n);
        chk("s2_bounce_latency", n, 7);
        idle(10);
        chk("s2_press_count", press_cnt[0] - p0, 1);
        KEY[0] = 1'b1;
        idle(12);

        // Scenario 3: 3-cycle glitch on KEY[1]
        p1 = press_cnt[1]; r1 = rel_cnt[1];
        KEY[1] = 1'b0;
        idle(3);
        KEY[1] = 1'b1;
        idle(15);
        chk("s3_glitch_level", 32'(key_level[1]), 32'h0);
        chk("s3_glitch_pulses", (press_cnt[1] - p1) + (rel_cnt[1] - r1), 0);

        // Scenario 4: switches
        SW = 10'h201;
        @(posedge clk); #1;
        chk("s4_sync_edge1", 32'(sw_sync), 32'h0);
        @(posedge clk); #1;
        chk("s4_sync_edge2", 32'(sw_sync), 32'h201);
        chk("s4_change_edge2", 32'(sw_change), 32'h201);
        @(posedge clk); #1;
        chk("s4_change_edge3", 32'(sw_change), 32'h0);
        idle(2);

        // Scenario 5: reset while the press is pending
        p0 = press_cnt[0];
        KEY[0] = 1'b0;
        idle(4);
        rst = 1'b1;
        #1;
        chk("s5_reset_immediate", {sw_sync, sw_change, key_level, key_press, key_release}, 32'h0);
        idle(2);
        chk("s5_no_pulse_in_reset", press_cnt[0] - p0, 0);
        rst = 1'b0;
        measure_level(0, 1'b1, n);
        chk("s5_press_after_reset", n, 7);
        idle(10);
        chk("s5_press_count", press_cnt[0] - p0, 1);

        // Scenario 6: both keys released together
        KEY = 2'b00;
        idle(12);
        chk("s6_both_pressed", 32'(key_level), 32'h3);
        r0 = rel_cnt[0]; r1 = rel_cnt[1];
        KEY = 2'b11;
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (key_release !== 2'b00) begin
                n = i;
                break;
            end
        end
        chk("s6_release_latency", n, 7);
        chk("s6_release_both", 32'(key_release), 32'h3);
        idle(3);
        chk("s6_release_counts", (rel_cnt[0] - r0) * 16 + (rel_cnt[1] - r1), 17);

        // Randomized traffic: alternating noisy and quiet stretches.
        for (int blk = 0; blk < 60; blk++) begin
            int noisy;
            noisy = ($urandom_range(0, 2) == 0) ? 1 : 0;
            for (int c = 0; c < 30; c++) begin
                if (noisy != 0) begin
                    for (int k = 0; k < 2; k++)
                        if ($urandom_range(0, 3) == 0) KEY[k] = ~KEY[k];
                end else if (c == 0) begin
                    KEY = 2'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 15) == 0) SW = 10'($urandom_range(0, 1023));
                idle(1);
            end
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
